// File: rtl/accel_disp_pkg.sv
// Shared constants, FSM state type and helpers for the accelerometer BCD display path.
package accel_disp_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      STORE = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Largest value representable in 'digits' decimal digits (10^digits - 1).
   function automatic logic [63:0] bcd_max(input int digits);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < digits; i++) begin
         r = r * 64'd10;
      end
      return r - 64'd1;
   endfunction

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble correction: adds 3 to every BCD digit that is 5 or more.
module bcd_add3_stage
   import accel_disp_pkg::*;
#(
   parameter int DIGITS = 5
) (
   input  logic [DIGITS*DIGIT_W-1:0] bcd_in,
   output logic [DIGITS*DIGIT_W-1:0] bcd_adj
);

   always_comb begin
      bcd_adj = bcd_in;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_in[d*DIGIT_W +: DIGIT_W] >= 4'd5) begin
            bcd_adj[d*DIGIT_W +: DIGIT_W] = bcd_in[d*DIGIT_W +: DIGIT_W] + 4'd3;
         end
      end
   end

endmodule

// File: rtl/accel_bcd_display.sv
// Sequential multi-channel binary-to-BCD converter for accelerometer samples.
// Define ACCEL_BCD_SIGNED_EN to treat samples as two's complement (default: unsigned).
module accel_bcd_display
   import accel_disp_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 16,
   parameter int DIGITS = 5
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             sample_valid,
   input  logic [NUM_CH*DATA_W-1:0]         sample_data,
   output logic                             busy,
   output logic                             out_valid,
   output logic [NUM_CH*DIGITS*DIGIT_W-1:0] bcd_out,
   output logic [NUM_CH-1:0]                sign_out,
   output logic [NUM_CH-1:0]                ovf_out
);

   localparam int BCD_W = DIGITS * DIGIT_W;
   localparam int SR_W  = BCD_W + DATA_W;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int MAX_W = DATA_W + 1;

   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   // When 10^DIGITS exceeds the sample range, clamp so the compare never flags overflow.
   localparam logic [63:0]      MAX64   = bcd_max(DIGITS);
   localparam logic [63:0]      MAG_TOP = (64'd1 << DATA_W) - 64'd1;
   localparam logic [MAX_W-1:0] BCD_MAX = (MAX64 > MAG_TOP) ? MAX_W'(MAG_TOP) : MAX_W'(MAX64);

   state_t                    state;
   logic [NUM_CH*DATA_W-1:0]  sample_q;
   logic [CH_W-1:0]           ch_idx;
   logic [CNT_W-1:0]          bit_cnt;
   logic [SR_W-1:0]           sr;
   logic                      cur_ovf;
   logic [NUM_CH*BCD_W-1:0]   stage_bcd;
   logic [NUM_CH-1:0]         stage_ovf;

   logic [DATA_W-1:0]         samp;
   logic [DATA_W-1:0]         mag;
   logic                      samp_sign;
   logic                      ovf_now;
   logic [BCD_W-1:0]          bcd_adj;
   logic [BCD_W-1:0]          store_val;
   logic [NUM_CH*BCD_W-1:0]   stage_bcd_nxt;
   logic [NUM_CH-1:0]         stage_ovf_nxt;

   assign samp = sample_q[int'(ch_idx)*DATA_W +: DATA_W];

`ifdef ACCEL_BCD_SIGNED_EN
   logic signed [DATA_W-1:0]  samp_s;
   assign samp_s    = signed'(samp);
   assign samp_sign = samp[DATA_W-1];
   // Most-negative input negates to itself, which reads correctly as an unsigned magnitude.
   assign mag       = samp_sign ? DATA_W'(unsigned'(-samp_s)) : samp;
`else
   assign samp_sign = 1'b0;
   assign mag       = samp;
`endif

   assign ovf_now   = {1'b0, mag} > BCD_MAX;
   assign store_val = cur_ovf ? {DIGITS{4'h9}} : sr[SR_W-1 -: BCD_W];

   bcd_add3_stage #(
      .DIGITS (DIGITS)
   ) u_add3 (
      .bcd_in  (sr[SR_W-1 -: BCD_W]),
      .bcd_adj (bcd_adj)
   );

   always_comb begin
      stage_bcd_nxt = stage_bcd;
      stage_ovf_nxt = stage_ovf;
      stage_bcd_nxt[int'(ch_idx)*BCD_W +: BCD_W] = store_val;
      stage_ovf_nxt[ch_idx] = cur_ovf;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         sample_q  <= '0;
         ch_idx    <= '0;
         bit_cnt   <= '0;
         sr        <= '0;
         cur_ovf   <= 1'b0;
         stage_bcd <= '0;
         stage_ovf <= '0;
         bcd_out   <= '0;
         ovf_out   <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (sample_valid) begin
                  sample_q <= sample_data;
                  ch_idx   <= '0;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               cur_ovf <= ovf_now;
               sr      <= {{BCD_W{1'b0}}, mag};
               bit_cnt <= '0;
               state   <= SHIFT;
            end
            SHIFT: begin
               sr      <= {bcd_adj[BCD_W-2:0], sr[DATA_W-1:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state <= STORE;
               end
            end
            STORE: begin
               stage_bcd <= stage_bcd_nxt;
               stage_ovf <= stage_ovf_nxt;
               // Publishing on the last STORE edge makes the results visible during DONE.
               if (ch_idx == LAST_CH) begin
                  bcd_out   <= stage_bcd_nxt;
                  ovf_out   <= stage_ovf_nxt;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  ch_idx <= ch_idx + 1'b1;
                  state  <= LOAD;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ACCEL_BCD_SIGNED_EN
   logic                 cur_sign;
   logic [NUM_CH-1:0]    stage_sign;
   logic [NUM_CH-1:0]    stage_sign_nxt;
   logic [NUM_CH-1:0]    sign_q;

   always_comb begin
      stage_sign_nxt = stage_sign;
      stage_sign_nxt[ch_idx] = cur_sign;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_sign   <= 1'b0;
         stage_sign <= '0;
         sign_q     <= '0;
      end else begin
         if (state == LOAD) begin
            cur_sign <= samp_sign;
         end
         if (state == STORE) begin
            stage_sign <= stage_sign_nxt;
            if (ch_idx == LAST_CH) begin
               sign_q <= stage_sign_nxt;
            end
         end
      end
   end

   assign sign_out = sign_q;
`else
   assign sign_out = '0;
`endif

endmodule
